// File: rtl/he_pkg.sv
// Shared types and default sizing for the homomorphic-encryption datapath blocks.
package he_pkg;

    localparam int          HE_DATA_WIDTH  = 64;
    localparam int          HE_TILE_WIDTH  = 8;
    localparam int          HE_POLY_DEGREE = 512;
    localparam logic [63:0] HE_MOD_VALUE   = 64'd1048193;
    localparam int          NUM_TILES      = HE_POLY_DEGREE / HE_TILE_WIDTH;

    typedef logic [HE_DATA_WIDTH-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } relin_acc_state_e;

endpackage

// File: rtl/relin_ct_accumulator_mod_add_lane.sv
// One coefficient lane: (a + b) reduced once by the modulus, plus an operand range flag.
module mod_add_lane
    import he_pkg::*;
#(
    parameter int          DATA_WIDTH = HE_DATA_WIDTH,
    parameter logic [63:0] MOD_VALUE  = HE_MOD_VALUE
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  range_err_o
);

    localparam logic [DATA_WIDTH:0]   MOD_EXT = (DATA_WIDTH+1)'(MOD_VALUE);
    localparam logic [DATA_WIDTH-1:0] MOD_DW  = DATA_WIDTH'(MOD_VALUE);

    logic [DATA_WIDTH:0] sum_full;

    // Single conditional subtract; out-of-range operands are passed through as computed.
    always_comb begin
        sum_full    = {1'b0, a_i} + {1'b0, b_i};
        sum_o       = (sum_full >= MOD_EXT) ? DATA_WIDTH'(sum_full - MOD_EXT)
                                            : DATA_WIDTH'(sum_full);
        range_err_o = (a_i >= MOD_DW) || (b_i >= MOD_DW);
    end

endmodule

// File: rtl/relin_ct_accumulator.sv
// Collects relinearised coefficient tiles, adds the matching c0/c1 coefficient mod q
// and assembles the full output polynomial. Stage A registers the operands, stage B
// registers the lane sums, and the result array is written from stage B.
module relin_ct_accumulator
    import he_pkg::*;
#(
    parameter int          DATA_WIDTH  = HE_DATA_WIDTH,
    parameter int          TILE_WIDTH  = HE_TILE_WIDTH,
    parameter int          POLY_DEGREE = HE_POLY_DEGREE,
    parameter logic [63:0] MOD_VALUE   = HE_MOD_VALUE
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_i,
    input  logic                                       key_select_i,
    input  logic [1:0][POLY_DEGREE-1:0][DATA_WIDTH-1:0] ct_i,
    input  logic                                       tile_valid_i,
    input  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0]      tile_i,
    output logic                                       ready_o,
    output logic [POLY_DEGREE-1:0][DATA_WIDTH-1:0]     result_o,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       range_err_o
);

    localparam int TILES = POLY_DEGREE / TILE_WIDTH;
    localparam int CNT_W = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int IDX_W = (POLY_DEGREE > 1) ? $clog2(POLY_DEGREE) : 1;
    localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(TILES - 1);

    relin_acc_state_e state_q;
    logic [CNT_W-1:0] tile_cnt_q;
    logic             key_sel_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             range_err_q;

    logic                                  a_valid_q;
    logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] a_tile_q;
    logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] a_ct_q;
    logic [IDX_W-1:0]                      a_base_q;

    logic                                  b_valid_q;
    logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] b_sum_q;
    logic                                  b_err_q;
    logic [IDX_W-1:0]                      b_base_q;

    logic [POLY_DEGREE-1:0][DATA_WIDTH-1:0] result_q;

    logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] lane_sum;
    logic [TILE_WIDTH-1:0]                 lane_err;

    logic             accept;
    logic             start_ok;
    logic [IDX_W-1:0] base_idx;

    assign accept   = tile_valid_i && (state_q == COLLECT);
    assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign base_idx = IDX_W'(tile_cnt_q) * IDX_W'(TILE_WIDTH);

    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign range_err_o = range_err_q;
    assign result_o    = result_q;

    // Pass sequencing, tile counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tile_cnt_q <= '0;
            key_sel_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q    <= COLLECT;
                        tile_cnt_q <= '0;
                        key_sel_q  <= key_select_i;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (tile_valid_i) begin
                        if (tile_cnt_q == LAST_TILE) begin
                            tile_cnt_q <= '0;
                            state_q    <= DRAIN;
                            ready_q    <= 1'b0;
                        end else begin
                            tile_cnt_q <= tile_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!a_valid_q && !b_valid_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage A: capture the incoming tile and the selected ciphertext coefficients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_tile_q  <= '0;
            a_ct_q    <= '0;
            a_base_q  <= '0;
        end else begin
            a_valid_q <= accept;
            if (accept) begin
                a_tile_q <= tile_i;
                a_base_q <= base_idx;
                for (int k = 0; k < TILE_WIDTH; k++) begin
                    a_ct_q[k] <= ct_i[key_sel_q][base_idx + IDX_W'(k)];
                end
            end
        end
    end

    for (genvar g = 0; g < TILE_WIDTH; g++) begin : g_lane
        mod_add_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MOD_VALUE  (MOD_VALUE)
        ) u_lane (
            .a_i         (a_tile_q[g]),
            .b_i         (a_ct_q[g]),
            .sum_o       (lane_sum[g]),
            .range_err_o (lane_err[g])
        );
    end

    // Stage B: register the reduced sums and whether any operand was out of range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_q <= 1'b0;
            b_sum_q   <= '0;
            b_err_q   <= 1'b0;
            b_base_q  <= '0;
        end else begin
            b_valid_q <= a_valid_q;
            if (a_valid_q) begin
                b_sum_q  <= lane_sum;
                b_err_q  <= |lane_err;
                b_base_q <= a_base_q;
            end
        end
    end

    // Result write-back; slots are only ever overwritten, never cleared between passes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (b_valid_q) begin
            for (int k = 0; k < TILE_WIDTH; k++) begin
                result_q[b_base_q + IDX_W'(k)] <= b_sum_q[k];
            end
        end
    end

    // Sticky range flag, cleared when a new pass starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else if (start_ok) begin
            range_err_q <= 1'b0;
        end else if (b_valid_q && b_err_q) begin
            range_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_relin_ct_accumulator.sv
module tb_relin_ct_accumulator;

    localparam int          DW = 64;
    localparam int          TW = 4;
    localparam int          PD = 16;
    localparam int          NT = PD / TW;
    localparam logic [63:0] Q  = 64'd1048193;

    logic clk = 1'b0;
    logic rst, start, key_sel, tile_valid;
    logic ready, busy, done, range_err;
    logic [1:0][PD-1:0][DW-1:0] ct;
    logic [TW-1:0][DW-1:0]      tile;
    logic [PD-1:0][DW-1:0]      result;

    int checks = 0;
    int errors = 0;

    logic [63:0] tv      [PD];
    logic [63:0] exp_res [PD];
    logic        exp_err;

    typedef struct {
        logic [63:0] ct0;
        logic [63:0] ct1;
        logic        key;
        logic [63:0] tilev;
        logic [63:0] expv;
        logic        err;
        logic        gap;
        logic        junk;
        logic        smid;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    relin_ct_accumulator #(
        .DATA_WIDTH  (DW),
        .TILE_WIDTH  (TW),
        .POLY_DEGREE (PD),
        .MOD_VALUE   (Q)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .key_select_i (key_sel),
        .ct_i         (ct),
        .tile_valid_i (tile_valid),
        .tile_i       (tile),
        .ready_o      (ready),
        .result_o     (result),
        .busy_o       (busy),
        .done_o       (done),
        .range_err_o  (range_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string name);
        for (int i = 0; i < PD; i++) chk($sformatf("%s[%0d]", name, i), result[i], exp_res[i]);
    endtask

    // Reference: each output slot is (tile coefficient + selected ct coefficient) mod q.
    task automatic build_expected(input logic key);
        exp_err = 1'b0;
        for (int i = 0; i < PD; i++) begin
            exp_res[i] = (tv[i] + ct[key][i]) % Q;
            if (tv[i] >= Q || ct[key][i] >= Q) exp_err = 1'b1;
        end
    endtask

    task automatic run_pass(input string name, input logic key, input logic gap,
                            input logic junk_start, input logic start_mid);
        int n;
        start   = 1'b1;
        key_sel = key;
        if (junk_start) begin
            tile_valid = 1'b1;
            for (int k = 0; k < TW; k++) tile[k] = 64'd424242;
        end
        tick;
        start      = 1'b0;
        tile_valid = 1'b0;
        key_sel    = ~key;
        chk({name, "_ready_start"}, ready, 1);
        chk({name, "_busy_start"}, busy, 1);
        chk({name, "_done_start"}, done, 0);
        chk({name, "_err_cleared"}, range_err, 0);
        for (int t = 0; t < NT; t++) begin
            tile_valid = 1'b1;
            for (int k = 0; k < TW; k++) tile[k] = tv[t*TW + k];
            tick;
            tile_valid = 1'b0;
            if (gap && t < NT - 1) begin
                if (start_mid && t == 0) start = 1'b1;
                tick;
                start = 1'b0;
                chk({name, "_done_gap"}, done, 0);
            end
        end
        chk({name, "_ready_drain"}, ready, 0);
        n = 0;
        while (!done && n < 20) begin
            tick;
            n++;
            if (n == 2) begin
                for (int k = 0; k < TW; k++)
                    chk($sformatf("%s_last_tile_t2[%0d]", name, k), result[PD-TW+k], exp_res[PD-TW+k]);
            end
        end
        chk({name, "_done_latency"}, 64'(n), 3);
        chk({name, "_busy_done"}, busy, 0);
        chk({name, "_ready_done"}, ready, 0);
        check_result({name, "_res"});
        chk({name, "_range_err"}, range_err, exp_err);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        key_sel    = 1'b0;
        tile_valid = 1'b0;
        tile       = '0;
        ct         = '0;

        tbl[0] = '{64'd7, 64'd99,      1'b0, 64'd5,       64'd12,      1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{64'd3, 64'd1,       1'b1, 64'd1048192, 64'd0,       1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{64'd0, 64'd1048192, 1'b1, 64'd1048192, 64'd1048191, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{64'd7, 64'd99,      1'b0, 64'd5,       64'd12,      1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{64'd7, 64'd9,       1'b0, 64'd1048193, 64'd7,       1'b1, 1'b0, 1'b0, 1'b0};

        repeat (2) tick;
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", range_err, 0);
        for (int i = 0; i < PD; i++) exp_res[i] = '0;
        check_result("rst_res");
        rst = 1'b0;
        tick;

        // Tiles offered in IDLE are dropped.
        tile_valid = 1'b1;
        for (int k = 0; k < TW; k++) tile[k] = 64'd77;
        repeat (2) tick;
        tile_valid = 1'b0;
        repeat (3) tick;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        check_result("idle_res");

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < PD; i++) begin
                ct[0][i]   = tbl[v].ct0;
                ct[1][i]   = tbl[v].ct1;
                tv[i]      = tbl[v].tilev;
                exp_res[i] = tbl[v].expv;
            end
            exp_err = tbl[v].err;
            run_pass($sformatf("vec%0d", v), tbl[v].key, tbl[v].gap, tbl[v].junk, tbl[v].smid);
        end

        // Tiles in DONE are dropped; result and sticky flag hold.
        tile_valid = 1'b1;
        for (int k = 0; k < TW; k++) tile[k] = 64'd55;
        repeat (2) tick;
        tile_valid = 1'b0;
        repeat (3) tick;
        chk("done_hold_done", done, 1);
        chk("done_hold_busy", busy, 0);
        chk("done_hold_err", range_err, 1);
        check_result("done_hold_res");

        // Reset in the middle of a pass.
        for (int i = 0; i < PD; i++) ct[0][i] = 64'd7;
        start   = 1'b1;
        key_sel = 1'b0;
        tick;
        start      = 1'b0;
        tile_valid = 1'b1;
        for (int k = 0; k < TW; k++) tile[k] = Q;
        tick;
        for (int k = 0; k < TW; k++) tile[k] = 64'd1;
        tick;
        tile_valid = 1'b0;
        tick;
        chk("midrst_pre_res0", result[0], 7);
        chk("midrst_pre_err", range_err, 1);
        rst = 1'b1;
        #1;
        chk("midrst_ready", ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", range_err, 0);
        for (int i = 0; i < PD; i++) exp_res[i] = '0;
        check_result("midrst_res");
        repeat (2) tick;
        rst = 1'b0;
        tick;
        for (int i = 0; i < PD; i++) begin
            ct[0][i] = 64'($urandom_range(0, 1048192));
            ct[1][i] = 64'($urandom_range(0, 1048192));
            tv[i]    = 64'($urandom_range(0, 1048192));
        end
        build_expected(1'b1);
        run_pass("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized passes against the arithmetic reference.
        for (int r = 0; r < 8; r++) begin
            logic key;
            key = 1'($urandom_range(0, 1));
            for (int i = 0; i < PD; i++) begin
                ct[0][i] = ($urandom_range(0, 7) == 0) ? Q - 1 : 64'($urandom_range(0, 1048192));
                ct[1][i] = ($urandom_range(0, 7) == 0) ? Q - 1 : 64'($urandom_range(0, 1048192));
                tv[i]    = ($urandom_range(0, 7) == 0) ? Q - 1 : 64'($urandom_range(0, 1048192));
            end
            if (r == 5) tv[3] = Q;
            build_expected(key);
            run_pass($sformatf("rand%0d", r), key, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
